// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg
// Shared front-end types and constants.
//   ID_ISSUE_BUF_DEPTH : depth used when instantiating id_issue_buffer
//   scoreboard_entry_t : decoded instruction record passed decode -> issue
// ---------------------------------------------------------------------------
package ariane_pkg;

   localparam int unsigned ID_ISSUE_BUF_DEPTH = 2;

   // Decoded instruction payload as seen by the scoreboard
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  fu;
      logic [6:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        valid;
   } scoreboard_entry_t;

endpackage : ariane_pkg

// File: rtl/id_issue_buffer.sv
// ---------------------------------------------------------------------------
// id_issue_buffer
// FIFO of decoded instructions between decode and issue, with single
// outstanding control-flow tracking. A control-flow entry is only accepted
// when no other control-flow entry is buffered and no issued branch is still
// awaiting resolution.
//
// Build option: define ID_ISSUE_BUFFER_BYPASS_EN for fall-through mode, where
// an entry accepted into an empty buffer is visible on the issue side in the
// same cycle (and is not stored if issue consumes it immediately).
//
// Ports
//   clk_i                 clock, rising edge
//   rst_i                 synchronous active-high reset
//   flush_i               drop all entries and branch-tracking state
//   decoded_instr_i       entry offered by decode
//   decoded_instr_valid_i decode offers an entry
//   is_ctrl_flow_i        offered entry is control flow
//   decoded_instr_ack_o   offered entry accepted this cycle
//   issue_instr_o         head entry toward issue
//   issue_instr_valid_o   head entry valid
//   is_ctrl_flow_o        head entry is control flow
//   issue_ack_i           issue consumed the head entry
//   resolve_branch_i      outstanding branch resolved by execute
//   count_o               occupancy
// ---------------------------------------------------------------------------
module id_issue_buffer
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  scoreboard_entry_t             decoded_instr_i,
   input  logic                          decoded_instr_valid_i,
   input  logic                          is_ctrl_flow_i,
   output logic                          decoded_instr_ack_o,
   output scoreboard_entry_t             issue_instr_o,
   output logic                          issue_instr_valid_o,
   output logic                          is_ctrl_flow_o,
   input  logic                          issue_ack_i,
   input  logic                          resolve_branch_i,
   output logic [$clog2(DEPTH+1)-1:0]    count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   scoreboard_entry_t mem_q [DEPTH];
   logic [DEPTH-1:0]  cf_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              branch_pending_q;

   logic              full;
   logic              empty;
   logic              cf_buffered;
   logic              branch_blocked;
   logic              ack;
   logic              push;
   logic              pop;
   logic              store;
   logic              mem_pop;
   logic              out_valid;
   logic              out_cf;
   scoreboard_entry_t out_entry;
   logic [PTR_W-1:0]  slot_ofs;
   logic [CNT_W-1:0]  count_d;
   logic              branch_pending_d;

   // Occupancy flags
   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
   end

   // Any occupied slot holding a control-flow entry; a slot is occupied when
   // its distance from the read pointer is below the current count
   always_comb begin
      cf_buffered = 1'b0;
      slot_ofs    = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         slot_ofs = PTR_W'(i) - rd_ptr_q;
         if ((CNT_W'(slot_ofs) < count_q) && cf_q[i]) begin
            cf_buffered = 1'b1;
         end
      end
   end

   // Input handshake; deliberately independent of issue_ack_i
   always_comb begin
      branch_blocked = is_ctrl_flow_i && (branch_pending_q || cf_buffered);
      ack            = !full && !flush_i && !rst_i && !branch_blocked;
      push           = decoded_instr_valid_i && ack;
   end

   // Issue-side view of the head entry and storage update qualifiers
`ifdef ID_ISSUE_BUFFER_BYPASS_EN
   logic bypass;

   always_comb begin
      bypass    = empty && push;
      out_valid = (!empty && !flush_i && !rst_i) || bypass;
      out_entry = bypass ? decoded_instr_i : mem_q[rd_ptr_q];
      out_cf    = bypass ? is_ctrl_flow_i : (!empty && cf_q[rd_ptr_q]);
      pop       = out_valid && issue_ack_i;
      // An entry consumed on the bypass path never touches storage
      store     = push && !(bypass && issue_ack_i);
      mem_pop   = pop && !bypass;
   end
`else
   always_comb begin
      out_valid = !empty && !flush_i && !rst_i;
      out_entry = mem_q[rd_ptr_q];
      out_cf    = !empty && cf_q[rd_ptr_q];
      pop       = out_valid && issue_ack_i;
      store     = push;
      mem_pop   = pop;
   end
`endif

   // Next occupancy and branch flag; a new branch issue wins over resolve
   always_comb begin
      count_d          = count_q + CNT_W'(store) - CNT_W'(mem_pop);
      branch_pending_d = branch_pending_q;
      if (pop && out_cf) begin
         branch_pending_d = 1'b1;
      end else if (resolve_branch_i) begin
         branch_pending_d = 1'b0;
      end
   end

   // Control state: pointers, count, control-flow tags, branch flag
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_ptr_q         <= '0;
         wr_ptr_q         <= '0;
         count_q          <= '0;
         cf_q             <= '0;
         branch_pending_q <= 1'b0;
      end else begin
         if (store) begin
            cf_q[wr_ptr_q] <= is_ctrl_flow_i;
            wr_ptr_q       <= wr_ptr_q + PTR_W'(1);
         end
         if (mem_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q          <= count_d;
         branch_pending_q <= branch_pending_d;
      end
   end

   // Payload storage, no reset needed
   always_ff @(posedge clk_i) begin
      if (store) begin
         mem_q[wr_ptr_q] <= decoded_instr_i;
      end
   end

   assign decoded_instr_ack_o = ack;
   assign issue_instr_o       = out_entry;
   assign issue_instr_valid_o = out_valid;
   assign is_ctrl_flow_o      = out_cf;
   assign count_o             = count_q;

endmodule : id_issue_buffer

// File: tb/tb_id_issue_buffer.sv
// ---------------------------------------------------------------------------
// tb_id_issue_buffer
// Directed bench for id_issue_buffer with an expected-entry queue.
// Honors ID_ISSUE_BUFFER_BYPASS_EN to match the DUT build.
// ---------------------------------------------------------------------------
module tb_id_issue_buffer;
   import ariane_pkg::*;

`ifdef ID_ISSUE_BUFFER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   localparam int unsigned CW = $clog2(ID_ISSUE_BUF_DEPTH + 1);

   typedef struct packed {
      scoreboard_entry_t e;
      logic              cf;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              flush_i;
   scoreboard_entry_t decoded_instr_i;
   logic              decoded_instr_valid_i;
   logic              is_ctrl_flow_i;
   logic              decoded_instr_ack_o;
   scoreboard_entry_t issue_instr_o;
   logic              issue_instr_valid_o;
   logic              is_ctrl_flow_o;
   logic              issue_ack_i;
   logic              resolve_branch_i;
   logic [CW-1:0]     count_o;

   exp_t sb [$];
   int   vectors     = 0;
   int   miscompares = 0;

   id_issue_buffer #(.DEPTH(ID_ISSUE_BUF_DEPTH)) dut (
      .clk_i                 (clk),
      .rst_i                 (rst_i),
      .flush_i               (flush_i),
      .decoded_instr_i       (decoded_instr_i),
      .decoded_instr_valid_i (decoded_instr_valid_i),
      .is_ctrl_flow_i        (is_ctrl_flow_i),
      .decoded_instr_ack_o   (decoded_instr_ack_o),
      .issue_instr_o         (issue_instr_o),
      .issue_instr_valid_o   (issue_instr_valid_o),
      .is_ctrl_flow_o        (is_ctrl_flow_o),
      .issue_ack_i           (issue_ack_i),
      .resolve_branch_i      (resolve_branch_i),
      .count_o               (count_o)
   );

   always #5 clk = ~clk;

   function automatic scoreboard_entry_t mk(input int k);
      scoreboard_entry_t e;
      e.pc    = 32'h8000_0000 + 32'(k) * 32'd4;
      e.fu    = 4'(k);
      e.op    = 7'(k * 3);
      e.rs1   = 5'(k);
      e.rs2   = 5'(k + 1);
      e.rd    = 5'(k + 2);
      e.valid = 1'b1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_count(input int e);
      chk("count", 64'(count_o), 64'(e));
   endtask

   // One cycle: drive at negedge, check comb outputs, settle past posedge
   task automatic step(input logic v, input int k, input logic cf, input logic iack,
                       input logic res, input logic fl, input logic e_ack, input logic e_val);
      exp_t front;
      @(negedge clk);
      decoded_instr_valid_i = v;
      decoded_instr_i       = mk(k);
      is_ctrl_flow_i        = cf;
      issue_ack_i           = iack;
      resolve_branch_i      = res;
      flush_i               = fl;
      #1;
      chk("ack", 64'(decoded_instr_ack_o), 64'(e_ack));
      chk("valid", 64'(issue_instr_valid_o), 64'(e_val));
      if (v && e_ack) sb.push_back('{e: mk(k), cf: cf});
      if (e_val) begin
         vectors++;
         assert (sb.size() != 0)
         else begin
            miscompares++;
            $error("FAIL sb_underflow: observed valid head, expected no entry");
         end
         if (sb.size() != 0) begin
            front = sb[0];
            chk("head", 64'(issue_instr_o), 64'(front.e));
            chk("head_cf", 64'(is_ctrl_flow_o), 64'(front.cf));
            if (iack) void'(sb.pop_front());
         end
      end
      @(posedge clk);
      #1;
      if (fl || rst_i) sb.delete();
   endtask

   initial begin
      #100000;
      $error("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; flush_i = 1'b0; decoded_instr_i = '0; decoded_instr_valid_i = 1'b0;
      is_ctrl_flow_i = 1'b0; issue_ack_i = 1'b0; resolve_branch_i = 1'b0;

      // Reset: no handshake while asserted
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 1, 0, 0, 0, 0);
      rst_i = 1'b0;
      chk_count(0);
      chk("rst_cf", 64'(is_ctrl_flow_o), 64'(0));

      // Fill: A, B accepted, C refused
      step(1, 1, 0, 0, 0, 0, 1, BYP);  chk_count(1);
      step(1, 2, 0, 0, 0, 0, 1, 1);    chk_count(2);
      step(1, 3, 0, 0, 0, 0, 0, 1);    chk_count(2);
      // Drain: no ack pass-through when full
      step(0, 0, 0, 1, 0, 0, 0, 1);    chk_count(1);
      step(0, 0, 0, 1, 0, 0, 1, 1);    chk_count(0);

      // Streaming with wrap
      for (int i = 0; i < 10; i++) begin
         step(1, 10 + i, 0, 1, 0, 0, 1, (i == 0) ? BYP : 1'b1);
         chk_count(BYP ? 0 : 1);
      end
      step(0, 0, 0, 1, 0, 0, 1, !BYP); chk_count(0);

      // Branch gating
      step(1, 30, 1, 0, 0, 0, 1, BYP); chk_count(1);
      step(0, 0, 0, 1, 0, 0, 1, 1);    chk_count(0);
      step(1, 31, 1, 0, 0, 0, 0, 0);
      step(1, 31, 1, 0, 0, 0, 0, 0);
      step(1, 31, 1, 0, 1, 0, 0, 0);
      step(1, 31, 1, 0, 0, 0, 1, BYP); chk_count(1);
      step(1, 33, 1, 0, 0, 0, 0, 1);   chk_count(1);
      step(1, 32, 0, 0, 0, 0, 1, 1);   chk_count(2);
      // Pop of control flow coinciding with resolve keeps branch pending
      step(0, 0, 0, 1, 1, 0, 0, 1);    chk_count(1);
      step(0, 0, 0, 1, 0, 0, 1, 1);    chk_count(0);
      step(1, 34, 1, 0, 0, 0, 0, 0);
      step(1, 34, 1, 0, 1, 0, 0, 0);
      step(1, 34, 1, 0, 0, 0, 1, BYP); chk_count(1);
      step(0, 0, 0, 1, 0, 0, 1, 1);    chk_count(0);
      step(0, 0, 0, 0, 1, 0, 1, 0);

      // Flush with branch pending and full buffer
      step(1, 39, 1, 0, 0, 0, 1, BYP); chk_count(1);
      step(0, 0, 0, 1, 0, 0, 1, 1);    chk_count(0);
      step(1, 40, 0, 0, 0, 0, 1, BYP); chk_count(1);
      step(1, 41, 0, 0, 0, 0, 1, 1);   chk_count(2);
      step(1, 42, 0, 1, 0, 1, 0, 0);   chk_count(0);
      step(0, 0, 0, 0, 0, 0, 1, 0);    chk_count(0);
      step(1, 43, 1, 0, 0, 0, 1, BYP); chk_count(1);

      // Reset mid-stream
      rst_i = 1'b1;
      step(1, 44, 0, 1, 0, 0, 0, 0);
      rst_i = 1'b0;
      chk_count(0);
      step(0, 0, 0, 0, 0, 0, 1, 0);    chk_count(0);

`ifdef ID_ISSUE_BUFFER_BYPASS_EN
      // Fall-through: consumed same cycle, never stored
      step(1, 50, 0, 1, 0, 0, 1, 1);   chk_count(0);
      step(1, 51, 1, 1, 0, 0, 1, 1);   chk_count(0);
      step(1, 52, 1, 0, 0, 0, 0, 0);   chk_count(0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_id_issue_buffer

// File: doc/id_issue_buffer.md
ID_ISSUE_BUFFER -- requirements
Module: id_issue_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered decoded entries; power of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  discard all buffered entries and branch-tracking state.
REQ-005 SHALL have port decoded_instr_i  input  scoreboard_entry_t  entry offered by decode.
REQ-006 SHALL have port decoded_instr_valid_i  input  1  decode offers an entry.
REQ-007 SHALL have port is_ctrl_flow_i  input  1  offered entry is a control-flow instruction.
REQ-008 SHALL have port decoded_instr_ack_o  output  1  entry accepted this cycle.
REQ-009 SHALL have port issue_instr_o  output  scoreboard_entry_t  head entry toward issue stage.
REQ-010 SHALL have port issue_instr_valid_o  output  1  head entry valid.
REQ-011 SHALL have port is_ctrl_flow_o  output  1  head entry is control flow.
REQ-012 SHALL have port issue_ack_i  input  1  issue stage consumed head entry.
REQ-013 SHALL have port resolve_branch_i  input  1  execute resolved the outstanding branch.
REQ-014 SHALL have port count_o  output  $clog2(DEPTH+1)  occupancy.

Function
REQ-015 SHALL push when decoded_instr_valid_i and decoded_instr_ack_o are both 1; SHALL pop when issue_instr_valid_o and issue_ack_i are both 1.
REQ-016 SHALL present entries in FIFO order; read/write pointers SHALL wrap modulo DEPTH.
REQ-017 SHALL drive issue_instr_valid_o = (count_o != 0) and not flush_i; issue_instr_o and is_ctrl_flow_o SHALL be the head entry and are don't-care when not valid.
REQ-018 SHALL drive decoded_instr_ack_o = not full, not flush_i, not rst_i, and not branch-blocked (REQ-020); ack SHALL NOT depend on issue_ack_i (no ready pass-through when full).
REQ-019 SHALL keep flag branch_pending: set on pop of a control-flow entry; cleared on resolve_branch_i; set wins over clear in the same cycle.
REQ-020 SHALL be branch-blocked when is_ctrl_flow_i=1 and (branch_pending=1 or any buffered entry is control flow); non-control-flow entries SHALL never be branch-blocked.
REQ-021 Simultaneous push and pop SHALL leave count_o unchanged; when full, pop frees the slot for the next cycle only.
REQ-022 flush_i SHALL, at the next edge, zero count_o and pointers and clear branch_pending; a push or pop in the flush cycle SHALL be suppressed.
REQ-023 Minimum latency push-to-valid SHALL be one cycle (without REQ-029 feature).
REQ-024 count_o SHALL never exceed DEPTH nor underflow; pop with count 0 SHALL be impossible by REQ-017.

Reset
REQ-025 While rst_i=1, decoded_instr_ack_o and issue_instr_valid_o SHALL be 0.
REQ-026 After the reset edge, count_o=0, pointers=0, branch_pending=0, is_ctrl_flow_o=0; storage contents need no reset.
REQ-027 rst_i asserted mid-operation SHALL drop all entries, identical to REQ-026.

Configuration
REQ-028 Macro ID_ISSUE_BUFFER_BYPASS_EN SHALL select fall-through mode.
REQ-029 Defined: when count_o=0 and no flush, an accepted input SHALL appear on issue_instr_o/valid/is_ctrl_flow_o in the same cycle; if issue_ack_i is also 1 the entry SHALL NOT be stored and a control-flow entry SHALL set branch_pending.
REQ-030 Undefined: outputs SHALL come only from storage; latency per REQ-023.

Structure
REQ-031 ariane_pkg SHALL hold constant ID_ISSUE_BUF_DEPTH (default 2) used by the instantiating top; scoreboard_entry_t is reused from ariane_pkg unchanged.
REQ-032 No sub-module; storage, pointers, counter and branch flag SHALL live in id_issue_buffer.

Verification
REQ-033 Fill: DEPTH=2, issue_ack_i=0, push A,B,C back-to-back -> A,B acked, C ack=0, count_o=2, head=A.
REQ-034 Stream: valid_i=1 and issue_ack_i=1 every cycle, 10 non-CF entries -> output order preserved, count_o stays 1 after first cycle (non-bypass).
REQ-035 Branch gating: push CF entry X, pop it, offer CF Y -> Y ack=0 until resolve_branch_i pulses; Y ack=1 the cycle after; resolve coinciding with pop of CF Z leaves branch_pending=1.
REQ-036 Flush: count_o=2, flush_i with push and pop offered -> neither happens; next cycle count_o=0, valid=0, branch_pending=0.
REQ-037 Reset mid-stream: count_o=1, rst_i 1 cycle -> ack=0, valid=0 during reset; count_o=0 after.
REQ-038 Bypass (macro defined): empty, push A with issue_ack_i=1 -> A on output same cycle, count_o remains 0.
